// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield geometry, line-clear FSM encoding and score table (used when SCORE_TABLE_EN is defined)
package tetris_pkg;
    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 5;
    localparam int ROW_W  = COLS * CELL_W;
    typedef enum logic [2:0] {IDLE, RD, EV, FILL, DONE} state_t;
    function automatic logic [15:0] score_of(input logic [4:0] k);
        return k == 5'd0 ? 16'd0 : k == 5'd1 ? 16'd40 : k == 5'd2 ? 16'd100 : k == 5'd3 ? 16'd300 : 16'd1200;
    endfunction
endpackage

// File: rtl/row_full_detect.sv
// row_full_detect: flags a map row whose every cell holds a nonzero colour code
module row_full_detect
    import tetris_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic             full
);
    logic [COLS-1:0] occupied;
    for (genvar c = 0; c < COLS; c++) begin : g_cell
        assign occupied[c] = |row[c*CELL_W +: CELL_W];
    end
    assign full = &occupied;
endmodule

// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: bottom-up row compaction and zero-fill after a lock; SCORE_TABLE_EN selects tabled scoring
module line_clear_sequencer
    import tetris_pkg::*;
(
    input  logic             VGA_CLK,
    input  logic             RESET,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [4:0]       lines_cleared,
    output logic [4:0]       map_addr,
    input  logic [ROW_W-1:0] map_rd_data,
    output logic             map_wr_en,
    output logic [ROW_W-1:0] map_wr_data,
    output logic [15:0]      score_inc
);
    localparam logic [4:0] LAST = 5'(ROWS - 1);
    state_t state, state_n;
    logic [4:0] src, src_n, dst, dst_n, k, k_n;
    logic full;
    row_full_detect u_full (.row(map_rd_data), .full(full));
    assign busy = state != IDLE;
    always_comb begin
        state_n     = state;
        src_n       = src;
        dst_n       = dst;
        k_n         = k;
        map_addr    = '0;
        map_wr_en   = 1'b0;
        map_wr_data = '0;
        case (state)
            IDLE: if (start) begin
                state_n = RD;
                src_n   = LAST;
                dst_n   = LAST;
                k_n     = '0;
            end
            RD: begin
                map_addr = src;
                state_n  = EV;
            end
            EV: begin
                // kept rows slide down to dst; rows already equal to dst stay put
                if (full) k_n = k + 5'd1;
                else begin
                    map_addr    = dst;
                    map_wr_en   = dst != src;
                    map_wr_data = map_rd_data;
                    dst_n       = dst - 5'd1;
                end
                if (src == 5'd0) state_n = k_n != 5'd0 ? FILL : DONE;
                else begin
                    src_n   = src - 5'd1;
                    state_n = RD;
                end
            end
            FILL: begin
                map_addr  = dst;
                map_wr_en = 1'b1;
                dst_n     = dst - 5'd1;
                state_n   = dst == 5'd0 ? DONE : FILL;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            k             <= '0;
            done          <= 1'b0;
            lines_cleared <= '0;
            score_inc     <= '0;
        end else begin
            state <= state_n;
            src   <= src_n;
            dst   <= dst_n;
            k     <= k_n;
            done  <= state == DONE;
            if (state == DONE) begin
                lines_cleared <= k;
`ifdef SCORE_TABLE_EN
                score_inc     <= score_of(k);
`else
                score_inc     <= {11'd0, k};
`endif
            end
        end
    end
endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb_line_clear_sequencer: directed line-clear passes against a behavioural row memory
module tb_line_clear_sequencer;
    import tetris_pkg::*;
    localparam logic [ROW_W-1:0] FULL_ROW = {COLS{5'd3}};
`ifdef SCORE_TABLE_EN
    localparam logic [15:0] S1 = 16'd40, S2 = 16'd100, S4 = 16'd1200, S20 = 16'd1200;
`else
    localparam logic [15:0] S1 = 16'd1, S2 = 16'd2, S4 = 16'd4, S20 = 16'd20;
`endif
    logic             clk = 1'b0;
    logic             rst, start;
    logic             busy, done, map_wr_en;
    logic [4:0]       lines_cleared, map_addr;
    logic [ROW_W-1:0] map_rd_data, map_wr_data;
    logic [15:0]      score_inc;
    logic [ROW_W-1:0] mem [ROWS];
    int n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0, cyc;
    line_clear_sequencer dut (
        .VGA_CLK(clk), .RESET(rst), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .map_addr(map_addr), .map_rd_data(map_rd_data),
        .map_wr_en(map_wr_en), .map_wr_data(map_wr_data), .score_inc(score_inc)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        map_rd_data = mem[map_addr];
        if (map_wr_en) begin
            mem[map_addr] = map_wr_data;
            wr_cnt++;
        end
        if (done) done_cnt++;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clear_map();
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
    endtask
    task automatic run(output int c);
        @(negedge clk);
        wr_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c     = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_map();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_wr_en", map_wr_en, 0);
        chk("rst_addr", map_addr, 0);
        chk("rst_score", score_inc, 0);
        rst = 1'b0;
        // empty map: no writes, 41-cycle latency
        run(cyc);
        chk("t1_cycle", cyc, 41);
        chk("t1_writes", wr_cnt, 0);
        chk("t1_lines", lines_cleared, 0);
        chk("t1_score", score_inc, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        // single full row at the bottom
        clear_map();
        mem[19] = FULL_ROW;
        mem[18] = 50'h1;
        run(cyc);
        chk("t2_cycle", cyc, 42);
        chk("t2_lines", lines_cleared, 1);
        chk("t2_score", score_inc, S1);
        chk("t2_row19", mem[19], 50'h1);
        chk("t2_row18", mem[18], 0);
        chk("t2_row0", mem[0], 0);
        chk("t2_writes", wr_cnt, 20);
        // four full rows, partial rows above and a partial top row
        clear_map();
        for (int r = 16; r < 20; r++) mem[r] = FULL_ROW;
        mem[15] = 50'h2;
        mem[14] = 50'h3;
        mem[0]  = 50'h7;
        run(cyc);
        chk("t3_cycle", cyc, 45);
        chk("t3_lines", lines_cleared, 4);
        chk("t3_score", score_inc, S4);
        chk("t3_row19", mem[19], 50'h2);
        chk("t3_row18", mem[18], 50'h3);
        chk("t3_row17", mem[17], 0);
        chk("t3_row4", mem[4], 50'h7);
        chk("t3_row3", mem[3], 0);
        chk("t3_row0", mem[0], 0);
        // non-adjacent full rows
        clear_map();
        mem[19] = FULL_ROW;
        mem[18] = 50'h5;
        mem[17] = FULL_ROW;
        mem[16] = 50'h6;
        run(cyc);
        chk("t4_cycle", cyc, 43);
        chk("t4_lines", lines_cleared, 2);
        chk("t4_score", score_inc, S2);
        chk("t4_row19", mem[19], 50'h5);
        chk("t4_row18", mem[18], 50'h6);
        chk("t4_row17", mem[17], 0);
        // every row full
        for (int r = 0; r < ROWS; r++) mem[r] = FULL_ROW;
        run(cyc);
        chk("all_cycle", cyc, 61);
        chk("all_lines", lines_cleared, 20);
        chk("all_score", score_inc, S20);
        chk("all_writes", wr_cnt, 20);
        chk("all_row0", mem[0], 0);
        chk("all_row19", mem[19], 0);
        // second start mid-pass is ignored
        clear_map();
        @(negedge clk);
        done_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("t5_done_count", done_cnt, 1);
        chk("t5_busy", busy, 0);
        // reset lands with a write pending in EV
        clear_map();
        mem[19] = FULL_ROW;
        mem[18] = 50'h1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pending_wr", map_wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_wr_en", map_wr_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_lines", lines_cleared, 0);
        rst    = 1'b0;
        wr_cnt = 0;
        repeat (30) @(negedge clk);
        chk("t6_no_writes", wr_cnt, 0);
        chk("t6_row18_kept", mem[18], 50'h1);
        // start and reset together
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_wins_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
